// File: rtl/branch_pkg.sv
// Shared constants and immediate-field extraction helpers for the branch target unit.
package branch_pkg;

  typedef enum logic [1:0] {
    MODE_BR   = 2'b00,
    MODE_JAL  = 2'b01,
    MODE_JALR = 2'b10,
    MODE_RSV  = 2'b11
  } mode_e;

  localparam int IMM_B_W = 13;
  localparam int IMM_J_W = 21;
  localparam int IMM_I_W = 12;

  localparam logic [2:0] LINK_INC = 3'd4;

  function automatic logic [IMM_B_W-1:0] imm_b(input logic [31:0] ins);
    return {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
  endfunction

  function automatic logic [IMM_J_W-1:0] imm_j(input logic [31:0] ins);
    return {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
  endfunction

  function automatic logic [IMM_I_W-1:0] imm_i(input logic [31:0] ins);
    return ins[31:20];
  endfunction

endpackage

// File: rtl/branch_imm_signex.sv
// Combinational sign-extender from IN_W bits to OUT_W bits (OUT_W must exceed IN_W).
module branch_imm_signex #(
  parameter int IN_W  = 12,
  parameter int OUT_W = 32
) (
  input  logic [IN_W-1:0]  imm,
  output logic [OUT_W-1:0] imm_ext
);

  assign imm_ext = {{(OUT_W-IN_W){imm[IN_W-1]}}, imm};

endmodule

// File: rtl/branch_target_unit.sv
// Two-stage pipelined branch/JAL/JALR target generator with valid/ready handshakes and flush.
module branch_target_unit
  import branch_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int C_EXT = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      mode,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] target,
  output logic [XLEN-1:0] link,
  output logic [1:0]      out_mode,
  output logic            misaligned,
  output logic            illegal
);

  logic [XLEN-1:0] imm_b_s, imm_j_s, imm_i_s, imm_sel_s, base_sel_s;
  logic            s1_valid_r;
  logic [XLEN-1:0] s1_imm_r, s1_base_r, s1_pc_r;
  logic [1:0]      s1_mode_r;
  logic [XLEN-1:0] sum_s, tgt_s, link_s;
  logic            mis_s, ill_s;
  logic            out_stall_s, s2_adv_s, accept_s;

  branch_imm_signex #(.IN_W(IMM_B_W), .OUT_W(XLEN)) u_sx_b (.imm(imm_b(instr)), .imm_ext(imm_b_s));
  branch_imm_signex #(.IN_W(IMM_J_W), .OUT_W(XLEN)) u_sx_j (.imm(imm_j(instr)), .imm_ext(imm_j_s));
  branch_imm_signex #(.IN_W(IMM_I_W), .OUT_W(XLEN)) u_sx_i (.imm(imm_i(instr)), .imm_ext(imm_i_s));

  assign out_stall_s = out_valid & ~out_ready;
  assign s2_adv_s    = s1_valid_r & ~out_stall_s;
  assign in_ready    = ~flush & (~s1_valid_r | ~out_stall_s);
  assign accept_s    = in_valid & in_ready;

  // Select immediate and base operand by instruction mode.
  always_comb begin
    imm_sel_s  = {XLEN{1'b0}};
    base_sel_s = pc;
    case (mode)
      MODE_BR:   begin imm_sel_s = imm_b_s; base_sel_s = pc;  end
      MODE_JAL:  begin imm_sel_s = imm_j_s; base_sel_s = pc;  end
      MODE_JALR: begin imm_sel_s = imm_i_s; base_sel_s = rs1; end
      default:   begin imm_sel_s = {XLEN{1'b0}}; base_sel_s = pc; end
    endcase
  end

  // Stage 1: operand register; flush only drops the valid bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      s1_imm_r   <= {XLEN{1'b0}};
      s1_base_r  <= {XLEN{1'b0}};
      s1_pc_r    <= {XLEN{1'b0}};
      s1_mode_r  <= 2'b00;
    end else if (flush) begin
      s1_valid_r <= 1'b0;
    end else if (accept_s) begin
      s1_valid_r <= 1'b1;
      s1_imm_r   <= imm_sel_s;
      s1_base_r  <= base_sel_s;
      s1_pc_r    <= pc;
      s1_mode_r  <= mode;
    end else if (s2_adv_s) begin
      s1_valid_r <= 1'b0;
    end else begin
      s1_valid_r <= s1_valid_r;
    end
  end

  // Target addition, JALR lsb clear, and illegal/misalignment qualification.
  always_comb begin
    sum_s  = s1_base_r + s1_imm_r;
    tgt_s  = sum_s;
    ill_s  = 1'b0;
    mis_s  = 1'b0;
    link_s = s1_pc_r + XLEN'(LINK_INC);
    case (s1_mode_r)
      MODE_JALR: tgt_s[0] = 1'b0;
      MODE_RSV:  begin tgt_s = {XLEN{1'b0}}; ill_s = 1'b1; end
      default:   tgt_s = sum_s;
    endcase
    if (ill_s) begin
      mis_s = 1'b0;
    end else if (C_EXT == 0) begin
      mis_s = tgt_s[1];
    end else begin
      mis_s = 1'b0;
    end
  end

  // Stage 2: output register, held stable while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      target     <= {XLEN{1'b0}};
      link       <= {XLEN{1'b0}};
      out_mode   <= 2'b00;
      misaligned <= 1'b0;
      illegal    <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (s2_adv_s) begin
      out_valid  <= 1'b1;
      target     <= tgt_s;
      link       <= link_s;
      out_mode   <= s1_mode_r;
      misaligned <= mis_s;
      illegal    <= ill_s;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= out_valid;
    end
  end

endmodule

// File: tb/tb_branch_target_unit.sv
// Directed self-checking bench: 32-bit/C_EXT=0 and 64-bit/C_EXT=1 instances.
module tb_branch_target_unit;

  logic clk;
  logic rst, flush, in_valid, out_ready;
  logic [1:0] mode;
  logic [31:0] instr, pc, rs1;
  logic in_ready, out_valid, misaligned, illegal;
  logic [31:0] target, link;
  logic [1:0] out_mode;

  logic flush64, v64, ordy64;
  logic [1:0] mode64;
  logic [31:0] instr64;
  logic [63:0] pc64, rs1_64;
  logic in_ready64, out_valid64, mis64, ill64;
  logic [63:0] target64, link64;
  logic [1:0] out_mode64;

  int checks = 0;
  int passes = 0;

  branch_target_unit #(.XLEN(32), .C_EXT(0)) dut32 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .instr(instr), .pc(pc), .rs1(rs1), .out_valid(out_valid),
    .out_ready(out_ready), .target(target), .link(link), .out_mode(out_mode),
    .misaligned(misaligned), .illegal(illegal)
  );

  branch_target_unit #(.XLEN(64), .C_EXT(1)) dut64 (
    .clk(clk), .rst(rst), .flush(flush64), .in_valid(v64), .in_ready(in_ready64),
    .mode(mode64), .instr(instr64), .pc(pc64), .rs1(rs1_64), .out_valid(out_valid64),
    .out_ready(ordy64), .target(target64), .link(link64), .out_mode(out_mode64),
    .misaligned(mis64), .illegal(ill64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_one(input string tag, input logic [1:0] m, input logic [31:0] ins,
                         input logic [31:0] p, input logic [31:0] r, input logic [31:0] et,
                         input logic [31:0] el, input logic emis, input logic eill);
    mode = m; instr = ins; pc = p; rs1 = r; in_valid = 1'b1;
    #1;
    check_eq({tag, "_rdy"}, {63'd0, in_ready}, 64'd1);
    tick();
    in_valid = 1'b0;
    check_eq({tag, "_lat"}, {63'd0, out_valid}, 64'd0);
    tick();
    check_eq({tag, "_vld"}, {63'd0, out_valid}, 64'd1);
    check_eq({tag, "_tgt"}, {32'd0, target}, {32'd0, et});
    check_eq({tag, "_lnk"}, {32'd0, link}, {32'd0, el});
    check_eq({tag, "_mode"}, {62'd0, out_mode}, {62'd0, m});
    check_eq({tag, "_mis"}, {63'd0, misaligned}, {63'd0, emis});
    check_eq({tag, "_ill"}, {63'd0, illegal}, {63'd0, eill});
    tick();
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    mode = 2'b00; instr = 32'd0; pc = 32'd0; rs1 = 32'd0;
    flush64 = 1'b0; v64 = 1'b0; ordy64 = 1'b1; mode64 = 2'b00;
    instr64 = 32'd0; pc64 = 64'd0; rs1_64 = 64'd0;
    tick();
    tick();
    check_eq("rst_vld", {63'd0, out_valid}, 64'd0);
    check_eq("rst_tgt", {32'd0, target}, 64'd0);
    check_eq("rst_lnk", {32'd0, link}, 64'd0);
    check_eq("rst_mode", {62'd0, out_mode}, 64'd0);
    check_eq("rst_flags", {62'd0, misaligned, illegal}, 64'd0);
    rst = 1'b0;
    #1;
    check_eq("rst_rdy", {63'd0, in_ready}, 64'd1);

    run_one("br_neg", 2'b00, 32'hFE00_0EE3, 32'h0000_1000, 32'h0, 32'h0000_0FFC, 32'h0000_1004, 1'b0, 1'b0);
    run_one("jal", 2'b01, 32'h0080_006F, 32'h8000_0000, 32'h0, 32'h8000_0008, 32'h8000_0004, 1'b0, 1'b0);
    run_one("jalr", 2'b10, 32'h0000_0067, 32'h8000_0004, 32'h0000_2003, 32'h0000_2002, 32'h8000_0008, 1'b1, 1'b0);
    run_one("jalr_neg", 2'b10, 32'hFFF0_0067, 32'h0000_0040, 32'h0000_0100, 32'h0000_00FE, 32'h0000_0044, 1'b1, 1'b0);
    run_one("wrap", 2'b00, 32'h0000_0463, 32'hFFFF_FFFC, 32'h0, 32'h0000_0004, 32'h0000_0000, 1'b0, 1'b0);
    run_one("br_mis", 2'b00, 32'h0000_0163, 32'h0000_1000, 32'h0, 32'h0000_1002, 32'h0000_1004, 1'b1, 1'b0);
    run_one("rsv", 2'b11, 32'h0080_006F, 32'h0000_1000, 32'h0000_2003, 32'h0, 32'h0000_1004, 1'b0, 1'b1);

    // Backpressure: two entries fill S2 and S1, then the consumer stalls.
    mode = 2'b00; instr = 32'h0000_0463;
    pc = 32'h100; in_valid = 1'b1; tick();
    pc = 32'h200; tick();
    out_ready = 1'b0; pc = 32'h300;
    #1;
    check_eq("bp_rdy0", {63'd0, in_ready}, 64'd0);
    check_eq("bp_tgt0", {32'd0, target}, 64'h108);
    tick();
    tick();
    check_eq("bp_hold_vld", {63'd0, out_valid}, 64'd1);
    check_eq("bp_hold_tgt", {32'd0, target}, 64'h108);
    check_eq("bp_hold_lnk", {32'd0, link}, 64'h104);
    check_eq("bp_hold_rdy", {63'd0, in_ready}, 64'd0);
    out_ready = 1'b1;
    #1;
    check_eq("bp_rel_rdy", {63'd0, in_ready}, 64'd1);
    tick();
    check_eq("bp_r1", {32'd0, target}, 64'h208);
    pc = 32'h400; tick();
    check_eq("bp_r2", {32'd0, target}, 64'h308);
    in_valid = 1'b0; tick();
    check_eq("bp_r3", {32'd0, target}, 64'h408);
    check_eq("bp_r3_vld", {63'd0, out_valid}, 64'd1);
    tick();
    check_eq("bp_nodup", {63'd0, out_valid}, 64'd0);

    // Flush with both stages full and a new input offered.
    pc = 32'h500; in_valid = 1'b1; tick();
    pc = 32'h600; tick();
    out_ready = 1'b0; pc = 32'h700; flush = 1'b1;
    #1;
    check_eq("fl_rdy", {63'd0, in_ready}, 64'd0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check_eq("fl_vld", {63'd0, out_valid}, 64'd0);
    out_ready = 1'b1;
    tick();
    check_eq("fl_s1_empty", {63'd0, out_valid}, 64'd0);
    check_eq("fl_rdy_back", {63'd0, in_ready}, 64'd1);

    // Reset in the middle of a stream.
    mode = 2'b01; instr = 32'h0080_006F; pc = 32'h1000; in_valid = 1'b1; tick();
    pc = 32'h2000; tick();
    check_eq("mrst_pre", {32'd0, target}, 64'h1008);
    rst = 1'b1; in_valid = 1'b0; tick();
    check_eq("mrst_vld", {63'd0, out_valid}, 64'd0);
    check_eq("mrst_tgt", {32'd0, target}, 64'd0);
    check_eq("mrst_lnk", {32'd0, link}, 64'd0);
    check_eq("mrst_mode", {62'd0, out_mode}, 64'd0);
    rst = 1'b0; tick();
    check_eq("mrst_s1", {63'd0, out_valid}, 64'd0);

    // 64-bit instance with compressed alignment.
    mode64 = 2'b00; instr64 = 32'h8000_0063; pc64 = 64'h0000_0001_0000_0000; v64 = 1'b1;
    tick();
    v64 = 1'b0;
    tick();
    check_eq("x64_vld", {63'd0, out_valid64}, 64'd1);
    check_eq("x64_tgt", target64, 64'h0000_0000_FFFF_F000);
    check_eq("x64_lnk", link64, 64'h0000_0001_0000_0004);
    check_eq("x64_mis", {63'd0, mis64}, 64'd0);
    mode64 = 2'b10; instr64 = 32'h0000_0067; rs1_64 = 64'h3; v64 = 1'b1;
    tick();
    v64 = 1'b0;
    tick();
    check_eq("x64_jalr_tgt", target64, 64'h2);
    check_eq("x64_jalr_mis", {63'd0, mis64}, 64'd0);
    check_eq("x64_jalr_mode", {62'd0, out_mode64}, 64'd2);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/branch_target_unit.md
Name: branch_target_unit

Overview:
- Parametrised, pipelined successor to the combinational B-type target generator.
- Computes control-transfer targets for conditional branch (B-type), JAL (J-type) and JALR (I-type) over an XLEN-wide datapath.
- Also produces the link address and misalignment/illegal flags.
- Sits between decode and the fetch redirect logic, with valid/ready handshakes on both sides and a flush input from the commit/redirect path.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64.
- C_EXT, 0, compressed-instruction support. 1 = 2-byte target alignment; 0 = 4-byte alignment.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  kills all in-flight entries.
- in_valid  in  1  request valid.
- in_ready  out  1  unit can accept the request this cycle.
- mode  in  2  00=BRANCH, 01=JAL, 10=JALR, 11=reserved.
- instr  in  32  full instruction word.
- pc  in  XLEN  address of the instruction.
- rs1  in  XLEN  base register value; used for JALR only.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- target  out  XLEN  computed target.
- link  out  XLEN  pc+4.
- out_mode  out  2  mode of the result.
- misaligned  out  1  target violates alignment.
- illegal  out  1  mode was 11.

Behaviour:
- Reset (rst=1 at a clock edge): s1_valid=0, out_valid=0; target, link, out_mode, misaligned and illegal are all 0. in_ready=1 from the first cycle after reset.
- Immediate extraction:
  - BRANCH: imm13 = {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - JAL: imm21 = {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - JALR: imm12 = instr[31:20].
  - All immediates are sign-extended to XLEN.
- Stage 1 (S1 register) captures: sign-extended imm, base (rs1 for JALR, pc otherwise), pc, mode.
- Stage 2 (output register) captures:
  - sum = base + imm, modulo 2^XLEN. Wrap-around is silent; no overflow flag.
  - For JALR, bit 0 of sum is forced to 0.
  - link = pc + 4, modulo 2^XLEN.
  - misaligned = target[1] when C_EXT=0; always 0 when C_EXT=1.
  - illegal = (mode==11). On illegal, target = 0 and misaligned = 0.
- Latency: exactly 2 cycles from an accepted input (in_valid & in_ready) to out_valid, when there is no backpressure. Throughput is 1 per cycle.
- Handshake:
  - out_stall = out_valid & ~out_ready.
  - s2_adv = s1_valid & ~out_stall.
  - in_ready = ~flush & (~s1_valid | ~out_stall).
  - The output register holds all fields stable while out_valid=1 & out_ready=0.
  - out_valid deasserts only on out_ready, flush or rst.
- Flush:
  - At the clock edge, s1_valid=0 and out_valid=0.
  - Any input presented in the same cycle is dropped; in_ready=0 during flush.
  - Data fields are not cleared.
- rst has priority over flush; flush has priority over a handshake.
- Reset mid-operation discards all entries. No partial result is ever output.
- Back-to-back stall: with S1 and S2 both full and out_ready=0, both registers hold and in_ready=0. When out_ready=1 returns, both advance in one cycle.

Decomposition:
- Package branch_pkg:
  - mode constants MODE_BR=2'b00, MODE_JAL=2'b01, MODE_JALR=2'b10, MODE_RSV=2'b11.
  - immediate widths IMM_B_W=13, IMM_J_W=21, IMM_I_W=12.
  - link increment constant LINK_INC=4.
- One sub-module, branch_imm_signex:
  - parameters IN_W, OUT_W.
  - combinational sign-extender, instantiated three times; replaces the fixed 13-bit extender.
- The adder is inline.

Test Plan:
- XLEN=32, BRANCH, pc=0x0000_1000, instr=0xFE00_0EE3 (imm=-4) -> 2 cycles later target=0x0000_0FFC, link=0x0000_1004, misaligned=0, illegal=0.
- JAL, pc=0x8000_0000, instr=0x0080_006F (imm=+8) -> target=0x8000_0008. Then JALR with rs1=0x0000_2003, instr=0x0000_0067 (imm=0) -> target=0x0000_2002; with C_EXT=0, misaligned=1.
- Wrap-around: BRANCH, pc=0xFFFF_FFFC, imm=+8 -> target=0x0000_0004, link=0x0000_0000.
- Backpressure: stream 4 back-to-back requests with out_ready=0 from cycle 3 -> in_ready=0 after S1 fills, output fields stable. Release out_ready -> results delivered in order, none lost or duplicated.
- Flush with S1 and S2 full and in_valid=1 -> next cycle out_valid=0, s1 empty, flushed input not delivered. Reset asserted mid-stream -> all outputs 0 the next cycle.
- mode=11 -> illegal=1, target=0, out_mode=11. XLEN=64, BRANCH, pc=0x0000_0001_0000_0000, imm=-4096 -> target=0x0000_0000_FFFF_F000.
